// File: rtl/rs15_13_stream_encoder_if.sv
// ----------------------------------------------------------------------------
// rs15_13_stream_encoder_if
//   Streaming bus of the RS(15,13) encoder: a message-symbol input channel and
//   a codeword-symbol output channel, each with a valid/ready handshake.
//   master : the side that feeds message symbols and consumes codeword symbols
//   slave  : the encoder itself
// Signals
//   in_valid  in_data holds a message symbol
//   in_ready  encoder accepts in_data this cycle
//   in_data   message symbol, highest-degree coefficient first
//   out_valid out_data holds a codeword symbol
//   out_ready downstream accepts out_data this cycle
//   out_data  codeword symbol, c14 first, p0 last
//   out_sop   marks c14
//   out_eop   marks p0
// ----------------------------------------------------------------------------
interface rs15_13_stream_encoder_if #(
    parameter int SYMBOL_WIDTH = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SYMBOL_WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SYMBOL_WIDTH-1:0] out_data;
    logic                    out_sop;
    logic                    out_eop;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop
    );
endinterface

// File: rtl/rs15_13_stream_encoder.sv
// ----------------------------------------------------------------------------
// rs15_13_stream_encoder
//   Symbol-serial systematic RS(15,13) encoder over GF(16) (x^4+x+1).
//   g(x) = x^2 + a^5*x + a^3. Each codeword is the 13 message symbols passed
//   straight through, followed by the two parity symbols p1, p0 taken from a
//   two-stage division LFSR.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of rs15_13_stream_encoder_if
// ----------------------------------------------------------------------------
module rs15_13_stream_encoder #(
    parameter int N            = 15,
    parameter int K            = 13,
    parameter int SYMBOL_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    rs15_13_stream_encoder_if.slave    bus
);

    typedef logic [SYMBOL_WIDTH-1:0] sym_t;
    typedef enum logic {ST_MSG, ST_PAR} state_t;

    localparam sym_t       GF_A5       = 4'h6;     // a^5
    localparam sym_t       GF_A3       = 4'h8;     // a^3
    localparam sym_t       GF_POLY_LOW = 4'h3;     // x^4 = x + 1
    localparam logic [3:0] MSG_LAST    = 4'(K - 1);
    localparam logic       PAR_LAST    = 1'(N - K - 1);

    // GF(16) product; with one operand constant it reduces to a few XORs.
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t acc;
        sym_t x;
        acc = '0;
        x   = a;
        for (int i = 0; i < SYMBOL_WIDTH; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[SYMBOL_WIDTH-2:0], 1'b0} ^ (x[SYMBOL_WIDTH-1] ? GF_POLY_LOW : '0);
        end
        return acc;
    endfunction

    state_t     r_state;
    logic [3:0] r_msg_cnt;
    logic       r_par_cnt;
    sym_t       r_r1;
    sym_t       r_r0;
    logic       r_out_valid;
    sym_t       r_out_data;
    logic       r_out_sop;
    logic       r_out_eop;

    logic       w_free;
    logic       w_in_ready;
    logic       w_in_fire;
    sym_t       w_fb;

    // The output register can take a new symbol when empty or being drained.
    assign w_free     = !r_out_valid || bus.out_ready;
    assign w_in_ready = (r_state == ST_MSG) && w_free;
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_fb       = bus.in_data ^ r_r1;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sop   = r_out_sop;
    assign bus.out_eop   = r_out_eop;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others (r_r1/r_r0 shift correctly).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_MSG;
            r_msg_cnt   <= '0;
            r_par_cnt   <= 1'b0;
            r_r1        <= '0;
            r_r0        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end else begin
            case (r_state)
                ST_MSG: begin
                    if (w_in_fire) begin
                        r_out_data  <= bus.in_data;
                        r_out_valid <= 1'b1;
                        r_out_sop   <= (r_msg_cnt == '0);
                        r_out_eop   <= 1'b0;
                        r_r1        <= r_r0 ^ gf_mul(w_fb, GF_A5);
                        r_r0        <= gf_mul(w_fb, GF_A3);
                        if (r_msg_cnt == MSG_LAST) begin
                            r_msg_cnt <= '0;
                            r_state   <= ST_PAR;
                        end else begin
                            r_msg_cnt <= r_msg_cnt + 4'd1;
                        end
                    end else if (w_free) begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_PAR: begin
                    if (w_free) begin
                        r_out_valid <= 1'b1;
                        r_out_sop   <= 1'b0;
                        if (r_par_cnt == PAR_LAST) begin
                            // p0 leaves; LFSR is cleared for the next codeword.
                            r_out_data <= r_r0;
                            r_out_eop  <= 1'b1;
                            r_par_cnt  <= 1'b0;
                            r_r1       <= '0;
                            r_r0       <= '0;
                            r_state    <= ST_MSG;
                        end else begin
                            r_out_data <= r_r1;
                            r_out_eop  <= 1'b0;
                            r_par_cnt  <= r_par_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_MSG;
            endcase
        end
    end

endmodule

// File: tb/tb_rs15_13_stream_encoder.sv
// ----------------------------------------------------------------------------
// tb_rs15_13_stream_encoder
//   Self-checking bench for rs15_13_stream_encoder. Expected codewords come
//   from polynomial long division by g(x) using log/antilog GF(16) tables;
//   every received codeword is also checked for zero syndromes at a and a^2.
// ----------------------------------------------------------------------------
module tb_rs15_13_stream_encoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rs15_13_stream_encoder_if bus ();

    rs15_13_stream_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [51:0] msg;   // [51:48] = m12 ... [3:0] = m0
        logic [3:0]  p1;
        logic [3:0]  p0;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_t[15];
    int          log_t[16];
    logic [5:0]  exp_q[$];      // {symbol, sop, eop}
    int          xfer_cyc[$];   // cycle number of every output transfer
    logic [3:0]  obs[$];
    logic [3:0]  last_p1;
    logic [3:0]  last_p0;
    int          cyc        = 0;
    int          ir_low_cnt = 0;
    int          rdy_pct    = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return 4'(exp_t[(log_t[a] + log_t[b]) % 15]);
    endfunction

    // Systematic codeword: message followed by the remainder of m(x)*x^2 / g(x).
    function automatic logic [59:0] model_cw(input logic [51:0] m);
        logic [3:0] c[15];
        logic [3:0] q;
        for (int i = 0; i < 13; i++) c[i] = m[51-4*i -: 4];
        c[13] = 4'h0;
        c[14] = 4'h0;
        for (int i = 0; i < 13; i++) begin
            q        = c[i];
            c[i]     = 4'h0;
            c[i+1]   = c[i+1] ^ gmul(q, 4'h6);
            c[i+2]   = c[i+2] ^ gmul(q, 4'h8);
        end
        return {m, c[13], c[14]};
    endfunction

    function automatic logic [3:0] syndrome(input logic [3:0] b);
        logic [3:0] s;
        s = 4'h0;
        foreach (obs[i]) s = gmul(s, b) ^ obs[i];
        return s;
    endfunction

    task automatic push_expected(input logic [51:0] m);
        logic [59:0] cw;
        cw = model_cw(m);
        for (int i = 0; i < 15; i++)
            exp_q.push_back({cw[59-4*i -: 4], 1'(i == 0), 1'(i == 14)});
    endtask

    // Sends nsym symbols of m; hold=1 keeps in_valid asserted for a follow-on message.
    task automatic send_msg(input logic [51:0] m, input int gap_pct, input int nsym, input bit hold);
        bit fired;
        int budget;
        push_expected(m);
        for (int i = 0; i < nsym; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                @(negedge clk); #1;
                bus.in_valid = 1'b0;
            end
            fired  = 1'b0;
            budget = 0;
            while (!fired) begin
                @(negedge clk); #1;
                bus.in_valid = 1'b1;
                bus.in_data  = m[51-4*i -: 4];
                #1;
                fired = bus.in_ready;
                budget++;
                if (!fired && budget > 200) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL in_ready_timeout: symbol %0d not accepted", i);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        if (!hold) begin
            @(negedge clk); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // out_ready driver
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk); #1;
            bus.out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Output monitor: samples 2 ns before the rising edge, after all drivers settle.
    initial begin
        logic       prev_v;
        logic       prev_r;
        logic [6:0] prev_f;
        logic [5:0] e;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_f = '0;
        forever begin
            @(negedge clk); #3;
            cyc++;
            if (!rst_n) begin
                prev_v = 1'b0;
                continue;
            end
            if (prev_v && !prev_r)
                check("stall_hold", {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop}, prev_f);
            if (!bus.in_ready) ir_low_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got %0h with nothing expected", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_symbol", {bus.out_data, bus.out_sop, bus.out_eop}, e);
                end
                if (bus.out_sop) obs.delete();
                obs.push_back(bus.out_data);
                if (bus.out_eop) begin
                    check("codeword_length", obs.size(), 15);
                    check("syndromes_a_a2", {syndrome(4'h2), syndrome(4'h4)}, 8'h00);
                    if (obs.size() == 15) begin
                        last_p1 = obs[13];
                        last_p0 = obs[14];
                    end
                end
            end
            prev_v = bus.out_valid;
            prev_r = bus.out_ready;
            prev_f = {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[4];
        int          e;
        int          n0;
        int          ir0;
        logic [63:0] rnd;
        logic [51:0] m;

        vecs[0] = '{msg: 52'h0,   p1: 4'h0, p0: 4'h0};
        vecs[1] = '{msg: 52'h1,   p1: 4'h6, p0: 4'h8};
        vecs[2] = '{msg: 52'h10,  p1: 4'hF, p0: 4'h5};
        vecs[3] = '{msg: 52'h100, p1: 4'h1, p0: 4'h1};

        e = 1;
        log_t[0] = 0;
        for (int i = 0; i < 15; i++) begin
            exp_t[i] = e;
            log_t[e] = i;
            e = e << 1;
            if ((e & 16) != 0) e = e ^ 'h13;
        end

        // Reset state
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 4'h0;
        repeat (3) begin
            @(negedge clk); #3;
            check("reset_outputs", {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop}, 7'h0);
        end
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Directed parity vectors, no stalls: 15 consecutive output transfers each
        foreach (vecs[v]) begin
            n0 = xfer_cyc.size();
            send_msg(vecs[v].msg, 0, 13, 1'b0);
            wait_drain();
            check($sformatf("vec%0d_p1", v), last_p1, vecs[v].p1);
            check($sformatf("vec%0d_p0", v), last_p0, vecs[v].p0);
            check($sformatf("vec%0d_nout", v), xfer_cyc.size() - n0, 15);
            if (xfer_cyc.size() - n0 == 15)
                check($sformatf("vec%0d_span", v), xfer_cyc[$] - xfer_cyc[n0], 14);
        end

        // Random messages with input gaps and output stalls
        rdy_pct = 60;
        for (int r = 0; r < 10; r++) begin
            rnd = {$urandom(), $urandom()};
            m   = (r == 0) ? {13{4'hF}} : rnd[51:0];
            send_msg(m, 30, 13, 1'b0);
        end
        rdy_pct = 100;
        wait_drain();

        // Three back-to-back codewords, valid and ready held high
        n0  = xfer_cyc.size();
        ir0 = ir_low_cnt;
        for (int r = 0; r < 3; r++) begin
            rnd = {$urandom(), $urandom()};
            send_msg(rnd[51:0], 0, 13, (r != 2));
        end
        wait_drain();
        check("b2b_nout", xfer_cyc.size() - n0, 45);
        if (xfer_cyc.size() - n0 == 45)
            check("b2b_span", xfer_cyc[$] - xfer_cyc[n0], 44);
        check("b2b_in_ready_low", ir_low_cnt - ir0, 6);

        // Reset in the middle of a codeword, then a fresh codeword
        rnd = {$urandom(), $urandom()};
        send_msg(rnd[51:0], 0, 7, 1'b0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk); #3;
            check("midreset_outputs", {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop}, 7'h0);
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        n0 = xfer_cyc.size();
        send_msg(vecs[1].msg, 0, 13, 1'b0);
        wait_drain();
        check("post_reset_p1", last_p1, 4'h6);
        check("post_reset_p0", last_p0, 4'h8);
        check("post_reset_nout", xfer_cyc.size() - n0, 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
